// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, RESP timeout limit,
// ALU command codes and the flag-write enable rule.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [7:0] ARB_TIMEOUT = 8'd255;

  localparam logic [2:0] CMD_ADD = 3'b000;
  localparam logic [2:0] CMD_SUB = 3'b001;
  localparam logic [2:0] CMD_AND = 3'b010;
  localparam logic [2:0] CMD_ORR = 3'b011;
  localparam logic [2:0] CMD_EOR = 3'b100;
  localparam logic [2:0] CMD_MOV = 3'b101;
  localparam logic [2:0] CMD_MVN = 3'b110;
  localparam logic [2:0] CMD_SLT = 3'b111;

  // Moves never update C/V, so the low enable is masked for them.
  function automatic logic flagw_cv(input logic s, input logic aluop, input logic [2:0] cmd);
    return s & aluop & (cmd != CMD_MOV) & (cmd != CMD_MVN);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester handshakes, ALU hookup and response signals for alu_arbiter.
// The slave modport is the arbiter; the master modport is the requester/ALU side.
interface alu_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_aluop;
  logic [NREQ-1:0]       req_s;
  logic [3*NREQ-1:0]     req_cmd;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;

  logic [3:0]            alu_control;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [WIDTH-1:0]      alu_result;
  logic [3:0]            alu_flags;

  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_result;
  logic [3:0]            rsp_flags;
  logic [1:0]            rsp_flagw;
  logic                  timeout_err;

  modport master (
    output req_valid, req_aluop, req_s, req_cmd, req_a, req_b, rsp_ready,
           alu_result, alu_flags,
    input  req_ready, alu_control, alu_a, alu_b,
           rsp_valid, rsp_result, rsp_flags, rsp_flagw, timeout_err
  );

  modport slave (
    input  req_valid, req_aluop, req_s, req_cmd, req_a, req_b, rsp_ready,
           alu_result, alu_flags,
    output req_ready, alu_control, alu_a, alu_b,
           rsp_valid, rsp_result, rsp_flags, rsp_flagw, timeout_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping.
// Zero latency; o_gnt is one-hot or zero, o_idx is 0 when nothing is requested.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx
);

  always_comb begin
    int  j;
    logic found;
    o_gnt = '0;
    o_idx = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(i_ptr) + k) % NREQ;
      if (!found && i_req[j]) begin
        found    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU among NREQ requesters: accept, one EXEC cycle, then a held
// response (>=3 cycles/op); req_ready is low while busy. RESP timeout via ALU_ARB_TIMEOUT_EN.
module alu_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);
  import alu_arb_pkg::*;

  localparam int IW = $clog2(NREQ);

  arb_state_t       r_state;
  arb_state_t       w_next;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_win;
  logic [2:0]       r_cmd;
  logic             r_s;
  logic             r_aluop;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  logic [NREQ-1:0]  w_gnt;
  logic [IW-1:0]    w_gnt_idx;
  logic             w_accept;
  logic             w_rsp_done;
  logic             w_drop;
  logic [IW-1:0]    w_ptr_nxt;
  logic [2:0]       w_sel_cmd;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx)
  );

  assign w_accept   = (r_state == IDLE) && (|w_gnt);
  assign w_rsp_done = (r_state == RESP) && bus.rsp_ready[r_win];
  assign w_ptr_nxt  = (r_win == IW'(NREQ - 1)) ? '0 : r_win + IW'(1);

  assign w_sel_cmd = bus.req_cmd[3*int'(w_gnt_idx) +: 3];
  assign w_sel_a   = bus.req_a[WIDTH*int'(w_gnt_idx) +: WIDTH];
  assign w_sel_b   = bus.req_b[WIDTH*int'(w_gnt_idx) +: WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    bus.req_ready   = '0;
    bus.alu_control = '0;
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    bus.rsp_valid   = '0;
    case (r_state)
      IDLE: begin
        bus.req_ready = w_gnt;
        if (w_accept) w_next = EXEC;
      end
      EXEC: begin
        bus.alu_control = {1'b0, r_cmd};
        bus.alu_a       = r_a;
        bus.alu_b       = r_b;
        w_next          = RESP;
      end
      RESP: begin
        bus.rsp_valid = NREQ'(1) << r_win;
        if (w_rsp_done || w_drop) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr    <= '0;
      r_win    <= '0;
      r_cmd    <= '0;
      r_s      <= 1'b0;
      r_aluop  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      if (w_accept) begin
        r_win   <= w_gnt_idx;
        r_cmd   <= w_sel_cmd;
        r_s     <= bus.req_s[w_gnt_idx];
        r_aluop <= bus.req_aluop[w_gnt_idx];
        r_a     <= w_sel_a;
        r_b     <= w_sel_b;
      end
      if (r_state == EXEC) begin
        r_result <= bus.alu_result;
        r_flags  <= bus.alu_flags;
      end
      // A dropped response still moves the pointer on so the stalled requester loses its turn.
      if (w_rsp_done || w_drop) r_ptr <= w_ptr_nxt;
    end
  end

  assign bus.rsp_result = r_result;
  assign bus.rsp_flags  = r_flags;
  assign bus.rsp_flagw  = {r_s, flagw_cv(r_s, r_aluop, r_cmd)};

`ifdef ALU_ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_timeout_err;

  // The 255th stalled RESP cycle is the one that drops; the error pulse follows in IDLE.
  assign w_drop = (r_state == RESP) && !bus.rsp_ready[r_win] &&
                  (r_cnt == ARB_TIMEOUT - 8'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_drop;
      if (r_state == EXEC) begin
        r_cnt <= '0;
      end else if ((r_state == RESP) && !bus.rsp_ready[r_win]) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  assign w_drop          = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single ALU datapath among `NREQ` requesters (lanes/cores) using round-robin arbitration and valid/ready handshakes. It latches the winning request's command and operands, drives the ALU control and operand inputs for one execute cycle, and registers the result. It then returns the result, NZCV flags and flag-write enables to the winner. It sits between the requesters' decode stages and the shared ALU instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: operand/result width.

- `clk`  input  1  clock, rising edge.
- `reset`  input  1  asynchronous, active-low.
- `req_valid`  input  NREQ  request pending, one bit per requester.
- `req_ready`  output  NREQ  request accepted (one-hot or zero).
- `req_aluop`  input  NREQ  ALU-operation class bit per requester.
- `req_s`  input  NREQ  set-flags bit per requester.
- `req_cmd`  input  3*NREQ  command, requester i at [3i+2:3i].
- `req_a`, `req_b`  input  WIDTH*NREQ  operands, requester i at [WIDTH*i +: WIDTH].
- `alu_control`  output  4  to ALU.
- `alu_a`, `alu_b`  output  WIDTH  to ALU.
- `alu_result`  input  WIDTH  from ALU, combinational.
- `alu_flags`  input  4  NZCV from ALU.
- `rsp_valid`  output  NREQ  response pending (one-hot or zero).
- `rsp_ready`  input  NREQ  requester accepts response.
- `rsp_result`  output  WIDTH  registered result.
- `rsp_flags`  output  4  registered NZCV.
- `rsp_flagw`  output  2  flag-write enables.
- `timeout_err`  output  1  one-cycle pulse on dropped response.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner is the first set `req_valid` bit searching upward from `rr_ptr`, with wrap-around.
  - `req_ready[winner]` is asserted combinationally; the handshake is valid&ready.
  - On the handshake, latch cmd, s, aluop, a, b and winner index, then go to EXEC.
  - No valid request: stay in IDLE.
- EXEC:
  - `alu_control` = {1'b0, cmd}; `alu_a`/`alu_b` come from the latched operands.
  - At the end of the cycle, register `alu_result` and `alu_flags`, then go to RESP.
- RESP:
  - `rsp_valid[winner]` = 1 and the response outputs are stable.
  - On `rsp_ready[winner]`: `rr_ptr` = (winner+1) mod NREQ, then go to IDLE.
  - `rsp_ready` bits of non-winners are ignored.
- Flag-write rules:
  - `rsp_flagw[1]` = s.
  - `rsp_flagw[0]` = s & aluop & (cmd ∉ {3'b101, 3'b110}).
- `alu_control`, `alu_a` and `alu_b` are 0 outside EXEC.
- `req_ready` is 0 in EXEC and RESP. Requesters holding valid wait, with no loss.
- A requester may drop `req_valid` before being granted without error.
- Simultaneous requests are resolved by `rr_ptr` only; there is no fixed priority.
- Async reset at any time:
  - State returns to IDLE and `rr_ptr` = 0.
  - All registers and outputs go to 0; any in-flight operation is discarded.

## Timing
- Accept at cycle T, EXEC at T+1, `rsp_valid` at T+2.
- With immediate `rsp_ready`, the FSM is back in IDLE at T+3. Maximum throughput is one op per 3 cycles.
- Outputs after reset: `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_flags`=0, `rsp_flagw`=0, `alu_*`=0, `timeout_err`=0.
- `req_ready` is combinational from `req_valid` and state. All other outputs are registered or state-decoded.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to RESP and increments each RESP cycle without `rsp_ready[winner]`.
  - When the count reaches 255, the response is dropped: `timeout_err` pulses for 1 cycle, `rr_ptr` advances past the winner, and the FSM goes to IDLE.
- Not defined: RESP waits indefinitely and `timeout_err` is tied to 0. The port exists in both builds.

## Structure
- Package `alu_arb_pkg` holds:
  - the `arb_state_t` enum {IDLE, EXEC, RESP};
  - `ARB_TIMEOUT` = 8'd255;
  - named 3-bit command constants, including the non-flag-writing codes 3'b101 and 3'b110.
- Sub-module `rr_arbiter`: combinational round-robin one-hot grant from `req_valid` and `rr_ptr`. The FSM and datapath registers stay in `alu_arbiter`.

## Test plan
- Single request: requester 2, cmd=000, s=1, aluop=1, a=5, b=3. Required: `req_ready[2]` at T, `alu_control`=0000 at T+1, `rsp_valid[2]` at T+2, `rsp_flagw`=2'b11.
- All four requesters valid continuously from reset: grants in order 0,1,2,3,0, each with `rsp_ready` held high, spaced 3 cycles apart.
- cmd=101, s=1, aluop=1: `rsp_flagw`=2'b10. cmd=000, s=0: `rsp_flagw`=2'b00.
- `rsp_ready` withheld for 10 cycles: `rsp_valid` and `rsp_result` stay stable and `req_ready` stays 0. Grant resumes the cycle after return to IDLE.
- Reset asserted during EXEC: all outputs are 0 immediately, and the next grant after release goes to the lowest valid index from 0.
- With `ALU_ARB_TIMEOUT_EN`, `rsp_ready` never asserted: `timeout_err` pulses once 255 cycles after entering RESP, then the next requester is granted.
